// File: rtl/envio_resposta_uart_pkg.sv
// Shared definitions for the UART response sender: FSM states, 8N1 frame constants,
// and the response codes agreed with the sensor-connection block.
package envio_resposta_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [7:0] RESP_OK              = 8'h07;
    localparam logic [7:0] RESP_HUMIDITY        = 8'h08;
    localparam logic [7:0] RESP_TEMPERATURE     = 8'h09;
    localparam logic [7:0] RESP_INVALID         = 8'h0F;
    localparam logic [7:0] RESP_SENSOR_ERROR    = 8'h1F;
    localparam logic [7:0] RESP_CONT_NOT_ACTIVE = 8'hAA;
    localparam logic [7:0] RESP_CONT_ACTIVE     = 8'hFF;

endpackage

// File: rtl/envio_resposta_uart_gerador_baud.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 and wraps; clear holds it at zero.
// Latency: bit_tick is combinational on the last count of each bit period.
// Backpressure: none; free-running whenever clear is low.
module envio_resposta_uart_gerador_baud #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_tick = !clear && (count == LAST);

endmodule

// File: rtl/envio_resposta_uart.sv
// Serialises the (command, value) response pair as two back-to-back UART 8N1 bytes.
// Latency: tx falls 1 cycle after send; done pulses 1+20*CLKS_PER_BIT cycles after send.
// Backpressure: none; a send while busy is discarded and flagged with a dropped pulse.
module envio_resposta_uart
    import envio_resposta_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       dropped
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic        byte_sel;
    logic [2:0]  bit_idx;
    logic [7:0]  cmd_q;
    logic [7:0]  val_q;
    logic [7:0]  cur_byte;
    logic        baud_clear;
    logic        bit_tick;

    assign cur_byte   = byte_sel ? val_q : cmd_q;
    assign baud_clear = (state == IDLE);

    envio_resposta_uart_gerador_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_gerador_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= STOP_BIT;
            busy     <= 1'b0;
            done     <= 1'b0;
            dropped  <= 1'b0;
            byte_sel <= 1'b0;
            bit_idx  <= 3'd0;
            cmd_q    <= 8'h00;
            val_q    <= 8'h00;
        end else begin
            done    <= 1'b0;
            dropped <= send && (state != IDLE);

            case (state)
                IDLE: begin
                    tx <= STOP_BIT;
                    if (send) begin
                        cmd_q    <= response_command;
                        val_q    <= response_value;
                        byte_sel <= 1'b0;
                        bit_idx  <= 3'd0;
                        busy     <= 1'b1;
                        tx       <= START_BIT;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_tick) begin
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            tx    <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end

                STOP: begin
                    if (bit_tick) begin
                        if (!byte_sel) begin
                            // value byte follows immediately, no idle gap
                            byte_sel <= 1'b1;
                            tx       <= START_BIT;
                            state    <= START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            tx    <= STOP_BIT;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    tx    <= STOP_BIT;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_envio_resposta_uart.sv
// Directed bench for envio_resposta_uart at 8 clocks per bit.
module tb_envio_resposta_uart;
    import envio_resposta_uart_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       tx;
    logic       busy;
    logic       done;
    logic       dropped;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    envio_resposta_uart #(
        .CLOCK_FREQ(800),
        .BAUD_RATE (100)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .send             (send),
        .response_command (response_command),
        .response_value   (response_value),
        .tx               (tx),
        .busy             (busy),
        .done             (done),
        .dropped          (dropped)
    );

    // Line level for bit period idx (0..19) of a two-byte 8N1 frame.
    function automatic logic exp_bit(input logic [7:0] c, input logic [7:0] v, input int idx);
        logic [7:0] b;
        int p;
        b = (idx < 10) ? c : v;
        p = idx % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends (c, v) and checks every cycle of the frame; returns in the done cycle.
    task automatic run_frame(input logic [7:0] c, input logic [7:0] v,
                             input int drop_at, input bit toggle, input string tag);
        logic want_drop;
        response_command = c;
        response_value   = v;
        send = 1'b1;
        step();
        send = 1'b0;
        for (int i = 0; i < 160; i++) begin
            want_drop = (drop_at >= 0) && (i == drop_at + 1);
            checks++;
            if (tx !== exp_bit(c, v, i / 8))
                $display("FAIL %s tx cycle %0d: got %b expected %b", tag, i + 1, tx, exp_bit(c, v, i / 8));
            else passed++;
            checks++;
            if (busy !== 1'b1) $display("FAIL %s busy cycle %0d: got %b expected 1", tag, i + 1, busy);
            else passed++;
            checks++;
            if (done !== 1'b0) $display("FAIL %s done cycle %0d: got %b expected 0", tag, i + 1, done);
            else passed++;
            checks++;
            if (dropped !== want_drop)
                $display("FAIL %s dropped cycle %0d: got %b expected %b", tag, i + 1, dropped, want_drop);
            else passed++;
            if (toggle) begin
                response_command = 8'($urandom);
                response_value   = 8'($urandom);
            end
            send = (i == drop_at);
            if (send) begin
                response_command = RESP_OK;
                response_value   = RESP_OK;
            end
            step();
        end
        send = 1'b0;
        checks++;
        if (done !== 1'b1) $display("FAIL %s done at cycle 161: got %b expected 1", tag, done);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy at cycle 161: got %b expected 0", tag, busy);
        else passed++;
        checks++;
        if (tx !== 1'b1) $display("FAIL %s tx at cycle 161: got %b expected 1", tag, tx);
        else passed++;
        checks++;
        if (dropped !== 1'b0) $display("FAIL %s dropped at cycle 161: got %b expected 0", tag, dropped);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        send = 1'b0;
        response_command = 8'h00;
        response_value   = 8'h00;
        repeat (3) step();
        checks++;
        if (tx !== 1'b1) $display("FAIL reset tx: got %b expected 1", tx); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else passed++;
        checks++;
        if (dropped !== 1'b0) $display("FAIL reset dropped: got %b expected 0", dropped); else passed++;
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle after reset: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        else passed++;
    endtask

    task automatic test_frame_end(input string tag);
        step();
        checks++;
        if (done !== 1'b0) $display("FAIL %s done after pulse: got %b expected 0", tag, done);
        else passed++;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s idle after frame: got tx=%b busy=%b expected tx=1 busy=0", tag, tx, busy);
        else passed++;
    endtask

    task automatic test_basic_frame();
        run_frame(RESP_TEMPERATURE, 8'h1A, -1, 1'b0, "frame_09_1a");
        test_frame_end("frame_09_1a");
    endtask

    task automatic test_error_code();
        run_frame(RESP_SENSOR_ERROR, RESP_SENSOR_ERROR, -1, 1'b0, "frame_1f_1f");
        test_frame_end("frame_1f_1f");
    endtask

    task automatic test_dropped();
        run_frame(RESP_TEMPERATURE, 8'h1A, 40, 1'b0, "drop");
        test_frame_end("drop");
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL drop extra activity cycle %0d: got done=%b busy=%b expected 0 0", i, done, busy);
            else passed++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        run_frame(RESP_TEMPERATURE, 8'h1A, -1, 1'b0, "b2b_first");
        run_frame(RESP_INVALID, RESP_INVALID, -1, 1'b0, "b2b_second");
        test_frame_end("b2b_second");
    endtask

    task automatic test_mid_reset();
        response_command = RESP_TEMPERATURE;
        response_value   = 8'h1A;
        send = 1'b1;
        step();
        send = 1'b0;
        repeat (49) step();
        checks++;
        if (busy !== 1'b1) $display("FAIL midreset busy before reset: got %b expected 1", busy);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) $display("FAIL midreset tx immediate: got %b expected 1", tx); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL midreset busy immediate: got %b expected 0", busy); else passed++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL midreset idle cycle %0d: got tx=%b busy=%b done=%b expected 1 0 0",
                         i, tx, busy, done);
            else passed++;
            step();
        end
        run_frame(RESP_HUMIDITY, 8'h2D, -1, 1'b0, "after_reset_08_2d");
        test_frame_end("after_reset_08_2d");
    endtask

    task automatic test_input_toggle();
        run_frame(RESP_OK, RESP_CONT_NOT_ACTIVE, -1, 1'b1, "toggle_07_aa");
        test_frame_end("toggle_07_aa");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_error_code();
        test_dropped();
        test_back_to_back();
        test_mid_reset();
        test_input_toggle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
